cpu_wrapper_v3: RTL and testbench

- 8-bit accumulator-style CPU top level with a two-stage pipeline: IF, then EX/WB.
- Contains a 256x8 instruction memory, a 4x8 register file (R3 is the stack pointer), a PC, a CCR flag register and a registered output port.
- Implements the Format A (ALU/IO) and Format B (branch) instruction subset.
- The host bench preloads memory through hierarchy; the CPU then runs from address 0x00.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/cpu_wrapper_v3_alu8.sv | 93 +++++++++
 rtl/cpu_wrapper_v3_imem.sv | 22 ++
 rtl/cpu_wrapper_v3_pc_reg.sv | 24 ++
 rtl/cpu_wrapper_v3_regfile.sv | 41 ++++
 rtl/cpu_wrapper_v3.sv | 104 ++++++++++
 tb/tb_cpu_wrapper_v3.sv | 163 ++++++++++++++++
 7 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode, sub-select, flag-index and NOP encodings
//                for the cpu_wrapper_v3 accumulator CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Primary opcodes, instruction bits [7:4]
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_SHF = 4'd6;
    localparam logic [3:0] OP_IO  = 4'd7;
    localparam logic [3:0] OP_UNA = 4'd8;
    localparam logic [3:0] OP_JCC = 4'd9;
    localparam logic [3:0] OP_JMP = 4'd11;

    // Shift/carry sub-select (ra field of OP_SHF)
    localparam logic [1:0] SH_RLC  = 2'd0;
    localparam logic [1:0] SH_RRC  = 2'd1;
    localparam logic [1:0] SH_SETC = 2'd2;
    localparam logic [1:0] SH_CLRC = 2'd3;

    // IO sub-select (ra field of OP_IO)
    localparam logic [1:0] IO_OUT = 2'd2;
    localparam logic [1:0] IO_IN  = 2'd3;

    // Unary sub-select (ra field of OP_UNA)
    localparam logic [1:0] UN_NOT = 2'd0;
    localparam logic [1:0] UN_NEG = 2'd1;
    localparam logic [1:0] UN_INC = 2'd2;
    localparam logic [1:0] UN_DEC = 2'd3;

    // Unconditional branch sub-select (brx field of OP_JMP)
    localparam logic [1:0] BR_JMP = 2'd0;

    // CCR bit positions, CCR = {V,C,N,Z}. The conditional-branch brx code
    // (JZ/JN/JC/JV = 0..3) equals the index of the flag it tests.
    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;
    localparam int CCR_V = 3;

    localparam logic [7:0] NOP_INSTR = 8'h00;

endpackage
`default_nettype wire

// File: rtl/cpu_wrapper_v3_alu8.sv
`default_nettype none
// ============================================================================
//  Module      : alu8
//  Description : Combinational 8-bit ALU. Produces the result and the next
//                CCR value; flags not touched by an op pass through.
//  Ports       : op, sel (ra field), a (R[ra]), b (R[rb]), flags_in (CCR)
//                -> result, flags_out
//  Revision    : 1.0 - initial release
// ============================================================================
module alu8
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [1:0] sel,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] flags_in,
    output logic [7:0] result,
    output logic [3:0] flags_out
);

    logic [8:0] w_sum9;
    logic       w_zn;     // Z/N follow the result for this op

    always_comb begin
        result    = a;
        flags_out = flags_in;
        w_sum9    = 9'd0;
        w_zn      = 1'b0;
        case (op)
            OP_MOV: result = b;
            OP_ADD: begin
                w_sum9 = {1'b0, a} + {1'b0, b};
                result = w_sum9[7:0];
                flags_out[CCR_C] = w_sum9[8];
                flags_out[CCR_V] = (a[7] == b[7]) && (result[7] != a[7]);
                w_zn = 1'b1;
            end
            OP_SUB: begin
                // bit 8 of the 9-bit difference is the borrow
                w_sum9 = {1'b0, a} - {1'b0, b};
                result = w_sum9[7:0];
                flags_out[CCR_C] = w_sum9[8];
                flags_out[CCR_V] = (a[7] != b[7]) && (result[7] != a[7]);
                w_zn = 1'b1;
            end
            OP_AND: begin result = a & b; w_zn = 1'b1; end
            OP_OR:  begin result = a | b; w_zn = 1'b1; end
            OP_SHF: begin
                case (sel)
                    SH_RLC: begin
                        result = {b[6:0], flags_in[CCR_C]};
                        flags_out[CCR_C] = b[7];
                        w_zn = 1'b1;
                    end
                    SH_RRC: begin
                        result = {flags_in[CCR_C], b[7:1]};
                        flags_out[CCR_C] = b[0];
                        w_zn = 1'b1;
                    end
                    SH_SETC: flags_out[CCR_C] = 1'b1;
                    default: flags_out[CCR_C] = 1'b0;
                endcase
            end
            OP_UNA: begin
                w_zn = 1'b1;
                case (sel)
                    UN_NOT: result = ~b;
                    UN_NEG: result = 8'd0 - b;
                    UN_INC: begin
                        w_sum9 = {1'b0, b} + 9'd1;
                        result = w_sum9[7:0];
                        flags_out[CCR_C] = w_sum9[8];
                        flags_out[CCR_V] = (b == 8'h7F);
                    end
                    default: begin
                        w_sum9 = {1'b0, b} - 9'd1;
                        result = w_sum9[7:0];
                        flags_out[CCR_C] = w_sum9[8];
                        flags_out[CCR_V] = (b == 8'h80);
                    end
                endcase
            end
            default: ;
        endcase
        if (w_zn) begin
            flags_out[CCR_Z] = (result == 8'h00);
            flags_out[CCR_N] = result[7];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_wrapper_v3_imem.sv
`default_nettype none
// ============================================================================
//  Module      : imem
//  Description : Instruction ROM image, combinational read. Contents are
//                preloaded from outside through the hierarchy; there is no
//                write port.
//  Ports       : addr -> data
//  Revision    : 1.0 - initial release
// ============================================================================
module imem #(
    parameter int MEM_DEPTH = 256
) (
    input  logic [7:0] addr,
    output logic [7:0] data
);

    logic [7:0] mem [0:MEM_DEPTH-1];

    assign data = mem[addr];

endmodule
`default_nettype wire

// File: rtl/cpu_wrapper_v3_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : 8-bit program counter; increments with natural wrap, or
//                loads a branch target which takes priority.
//  Ports       : clk, rstn (async active-high), load, target -> pc_current
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_reg (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] target,
    output logic [7:0] pc_current
);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)      pc_current <= 8'h00;
        else if (load) pc_current <= target;
        else           pc_current <= pc_current + 8'd1;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_wrapper_v3_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 4x8 register file, two combinational read ports, one
//                write port. R3 is the stack pointer and resets to SP_RESET.
//  Ports       : clk, rstn (async active-high), ra_addr/rb_addr -> ra_data/
//                rb_data, we/waddr/wdata write port
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter logic [7:0] SP_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] ra_addr,
    input  logic [1:0] rb_addr,
    output logic [7:0] ra_data,
    output logic [7:0] rb_data,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata
);

    logic [7:0] regs [0:3];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            regs[0] <= 8'h00;
            regs[1] <= 8'h00;
            regs[2] <= 8'h00;
            regs[3] <= SP_RESET;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule
`default_nettype wire

// File: rtl/cpu_wrapper_v3.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_wrapper_v3
//  Description : 8-bit accumulator CPU top, two-stage pipeline (IF, EX/WB).
//                Fetch fills the IF/EX register every edge; EX decodes it,
//                writes back and updates CCR / O_Port on the next edge.
//  Ports       : clk, rstn (async active-high reset), I_Port (IN data),
//                int_sig (reserved, ignored), O_Port (registered OUT data)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_wrapper_v3
    import cpu_pkg::*;
#(
    parameter int         MEM_DEPTH = 256,
    parameter logic [7:0] SP_RESET  = 8'hFF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] I_Port,
    input  logic       int_sig,
    output logic [7:0] O_Port
);

    logic [7:0] w_pc, w_fetch, r_ir;
    logic [3:0] r_ccr, w_alu_flags, w_ccr_next;
    logic [7:0] w_ra_data, w_rb_data, w_alu_res, w_wdata;
    logic [1:0] w_waddr;
    logic       w_we, w_out_we, w_take;
    logic       unused_int;

    wire [3:0] w_op = r_ir[7:4];
    wire [1:0] w_ra = r_ir[3:2];
    wire [1:0] w_rb = r_ir[1:0];

    assign unused_int = int_sig;

    imem #(.MEM_DEPTH(MEM_DEPTH)) mem_inst (.addr(w_pc), .data(w_fetch));

    pc_reg PC (
        .clk(clk), .rstn(rstn), .load(w_take), .target(w_rb_data),
        .pc_current(w_pc)
    );

    regfile #(.SP_RESET(SP_RESET)) regfile_inst (
        .clk(clk), .rstn(rstn),
        .ra_addr(w_ra), .rb_addr(w_rb),
        .ra_data(w_ra_data), .rb_data(w_rb_data),
        .we(w_we), .waddr(w_waddr), .wdata(w_wdata)
    );

    alu8 alu_inst (
        .op(w_op), .sel(w_ra), .a(w_ra_data), .b(w_rb_data),
        .flags_in(r_ccr), .result(w_alu_res), .flags_out(w_alu_flags)
    );

    // EX decode: write-back destination, output strobe, branch resolution
    always_comb begin
        w_we       = 1'b0;
        w_waddr    = w_ra;
        w_wdata    = w_alu_res;
        w_out_we   = 1'b0;
        w_take     = 1'b0;
        w_ccr_next = w_alu_flags;
        case (w_op)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: w_we = 1'b1;
            OP_SHF: begin
                w_we    = (w_ra == SH_RLC) || (w_ra == SH_RRC);
                w_waddr = w_rb;
            end
            OP_IO: begin
                w_out_we = (w_ra == IO_OUT);
                w_we     = (w_ra == IO_IN);
                w_waddr  = w_rb;
                w_wdata  = I_Port;
            end
            OP_UNA: begin
                w_we    = 1'b1;
                w_waddr = w_rb;
            end
            OP_JCC: begin
                // brx doubles as the CCR index of the tested flag
                w_take = r_ccr[w_ra];
                if (w_take) w_ccr_next[w_ra] = 1'b0;
            end
            OP_JMP: w_take = (w_ra == BR_JMP);
            default: ;
        endcase
    end

    // A taken branch squashes the sequentially fetched instruction
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_ir   <= NOP_INSTR;
            r_ccr  <= 4'h0;
            O_Port <= 8'h00;
        end else begin
            r_ir  <= w_take ? NOP_INSTR : w_fetch;
            r_ccr <= w_ccr_next;
            if (w_out_we) O_Port <= w_rb_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_wrapper_v3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_wrapper_v3
//  Description : Directed self-checking bench for cpu_wrapper_v3. Programs
//                are preloaded through the hierarchy; expected values are
//                hand-computed per edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_wrapper_v3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       int_sig;
    logic [7:0] I_Port;
    logic [7:0] O_Port;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_wrapper_v3 #(.MEM_DEPTH(256), .SP_RESET(8'hFF)) dut (
        .clk(clk), .rstn(rstn), .I_Port(I_Port),
        .int_sig(int_sig), .O_Port(O_Port)
    );

    // Advance n rising edges, sampling 1 time unit after each; int_sig
    // toggles every cycle and must never matter.
    task automatic step(input int n);
        repeat (n) begin
            int_sig = ~int_sig;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = 8'h00;
    endtask

    initial begin
        rstn    = 1'b1;
        int_sig = 1'b0;
        I_Port  = 8'h00;

        // ---------------- Program 1: IO, ADD, JMP, SUB loop -------------
        clear_mem();
        dut.mem_inst.mem[0] = 8'h7C;  // IN  R0
        dut.mem_inst.mem[1] = 8'h7D;  // IN  R1
        dut.mem_inst.mem[2] = 8'h21;  // ADD R0,R1
        dut.mem_inst.mem[3] = 8'h78;  // OUT R0
        dut.mem_inst.mem[4] = 8'h7E;  // IN  R2
        dut.mem_inst.mem[5] = 8'hB2;  // JMP R2
        dut.mem_inst.mem[6] = 8'h89;  // INC R1 (flushed)
        dut.mem_inst.mem[7] = 8'h31;  // SUB R0,R1
        dut.mem_inst.mem[8] = 8'h78;  // OUT R0
        dut.mem_inst.mem[9] = 8'hB2;  // JMP R2
        step(2);
        chk("rst_pc",   dut.PC.pc_current, 8'h00);
        chk("rst_r0",   dut.regfile_inst.regs[0], 8'h00);
        chk("rst_r3",   dut.regfile_inst.regs[3], 8'hFF);
        chk("rst_out",  O_Port, 8'h00);
        chk("rst_ccr",  {4'h0, dut.r_ccr}, 8'h00);
        chk("rst_ir",   dut.r_ir, 8'h00);
        rstn = 1'b0;

        I_Port = 8'h05;
        step(2);                                              // edge 2
        chk("in_r0",    dut.regfile_inst.regs[0], 8'h05);
        I_Port = 8'h03;
        step(1);                                              // edge 3
        chk("in_r1",    dut.regfile_inst.regs[1], 8'h03);
        step(1);                                              // edge 4
        chk("add_r0",   dut.regfile_inst.regs[0], 8'h08);
        step(1);                                              // edge 5
        chk("out_8",    O_Port, 8'h08);
        I_Port = 8'h07;
        step(1);                                              // edge 6
        chk("in_r2",    dut.regfile_inst.regs[2], 8'h07);
        step(1);                                              // edge 7
        chk("jmp_pc",   dut.PC.pc_current, 8'h07);
        step(2);                                              // edge 9
        chk("sub1_r0",  dut.regfile_inst.regs[0], 8'h05);
        chk("flush_r1", dut.regfile_inst.regs[1], 8'h03);
        step(1);                                              // edge 10
        chk("out_5",    O_Port, 8'h05);
        step(1);                                              // edge 11
        chk("loop_pc",  dut.PC.pc_current, 8'h07);
        step(2);                                              // edge 13
        chk("sub2_r0",  dut.regfile_inst.regs[0], 8'h02);
        step(4);                                              // edge 17
        chk("sub3_r0",  dut.regfile_inst.regs[0], 8'hFF);
        chk("sub3_ccr", {4'h0, dut.r_ccr}, 8'h06);            // C=1 N=1

        // ---------------- Program 2: flags, JZ, overflow ----------------
        rstn = 1'b1;
        clear_mem();
        dut.mem_inst.mem[0]  = 8'h7C;  // IN  R0
        dut.mem_inst.mem[1]  = 8'h7D;  // IN  R1
        dut.mem_inst.mem[2]  = 8'h7E;  // IN  R2
        dut.mem_inst.mem[3]  = 8'h21;  // ADD R0,R1
        dut.mem_inst.mem[4]  = 8'h92;  // JZ  R2 (taken)
        dut.mem_inst.mem[5]  = 8'h89;  // INC R1 (flushed)
        dut.mem_inst.mem[8]  = 8'h92;  // JZ  R2 (not taken)
        dut.mem_inst.mem[9]  = 8'h7C;  // IN  R0
        dut.mem_inst.mem[10] = 8'h88;  // INC R0
        dut.mem_inst.mem[11] = 8'h78;  // OUT R0
        step(1);
        rstn = 1'b0;
        I_Port = 8'hFF;
        step(2);                                              // edge 2
        I_Port = 8'h01;
        step(1);                                              // edge 3
        I_Port = 8'h08;
        step(1);                                              // edge 4
        chk("p2_r2",    dut.regfile_inst.regs[2], 8'h08);
        step(1);                                              // edge 5
        chk("add0_r0",  dut.regfile_inst.regs[0], 8'h00);
        chk("add0_ccr", {4'h0, dut.r_ccr}, 8'h05);            // C=1 Z=1
        step(1);                                              // edge 6
        chk("jz_pc",    dut.PC.pc_current, 8'h08);
        chk("jz_ccr",   {4'h0, dut.r_ccr}, 8'h04);            // Z cleared
        step(2);                                              // edge 8
        chk("jznt_pc",  dut.PC.pc_current, 8'h0A);
        chk("jz_flush", dut.regfile_inst.regs[1], 8'h01);
        I_Port = 8'h7F;
        step(2);                                              // edge 10
        chk("inc_r0",   dut.regfile_inst.regs[0], 8'h80);
        chk("inc_ccr",  {4'h0, dut.r_ccr}, 8'h0A);            // V=1 N=1
        step(1);                                              // edge 11
        chk("out_80",   O_Port, 8'h80);

        // ---------------- Mid-run reset and restart ---------------------
        step(2);
        rstn = 1'b1;
        #1;
        chk("mid_pc",   dut.PC.pc_current, 8'h00);
        chk("mid_r3",   dut.regfile_inst.regs[3], 8'hFF);
        chk("mid_out",  O_Port, 8'h00);
        chk("mid_r0",   dut.regfile_inst.regs[0], 8'h00);
        chk("mid_ccr",  {4'h0, dut.r_ccr}, 8'h00);
        step(1);
        rstn = 1'b0;
        I_Port = 8'h33;
        step(2);
        chk("rs_r0",    dut.regfile_inst.regs[0], 8'h33);
        chk("rs_pc",    dut.PC.pc_current, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
